// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns mnemonic-level instruction requests into 32-bit machine words,
//   queues them in a small FIFO and emits each one with a sequential
//   instruction-memory word address. Feeds the program loader.
//
// Ports
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake (in_ready = FIFO not full)
//   in_op, in_rd, in_rs,    mnemonic request fields
//   in_rt, in_imm
//   load_addr, start_addr   reload the address counter
//   out_valid / out_ready   encoded-word handshake (out_valid = FIFO not empty)
//   out_instr, out_addr     FIFO head word and its address
//   err_illegal, err_range  sticky error flags, cleared by err_clr
//   instr_count             pops since reset, saturating (ENC_STATS_EN only)
//
// Configuration
//   ENC_STATS_EN : when defined, adds the instr_count output and its counter.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [25:0]       in_imm,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic              err_range,
  input  logic              err_clr
`ifdef ENC_STATS_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_range_q, err_range_d;

  logic [31:0]       enc_word_s;
  logic              enc_legal_s;
  logic              enc_itype_s;
  logic              full_s, empty_s;
  logic              accept_s, push_s, pop_s;

  // Combinational encoder: opcode/funct map and field packing per mnemonic.
  always_comb begin
    enc_word_s  = 32'h0000_0000;
    enc_legal_s = 1'b1;
    enc_itype_s = 1'b0;
    case (in_op)
      4'd0:  enc_word_s = {6'b000000, in_rs, in_rt, in_rd, 11'b00000000001};
      4'd1:  enc_word_s = {6'b000000, in_rs, in_rt, in_rd, 11'b00000000010};
      4'd2:  enc_word_s = {6'b000000, in_rs, in_rt, in_rd, 11'b00000001000};
      4'd3:  begin enc_word_s = {6'b000001, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      4'd4:  begin enc_word_s = {6'b000010, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      4'd5:  begin enc_word_s = {6'b001000, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      4'd6:  begin enc_word_s = {6'b001001, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      4'd7:  enc_word_s = {6'b010000, in_imm};
      4'd8:  begin enc_word_s = {6'b010010, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      4'd9:  begin enc_word_s = {6'b010011, in_rs, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      // LI has no base register: rs field is forced to zero.
      4'd10: begin enc_word_s = {6'b011000, 5'd0, in_rt, in_imm[15:0]}; enc_itype_s = 1'b1; end
      default: enc_legal_s = 1'b0;
    endcase
  end

  // FIFO status: pointers carry one extra wrap bit to tell full from empty.
  assign empty_s  = (wr_ptr_q == rd_ptr_q);
  assign full_s   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready = !full_s;
  assign out_valid = !empty_s;

  // Illegal ops complete the handshake but are never written.
  assign accept_s = in_valid && !full_s;
  assign push_s   = accept_s && enc_legal_s;
  assign pop_s    = !empty_s && out_ready;

  // Next-state for FIFO storage, pointers, address counter and error flags.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = enc_word_s;
    end else begin
      mem_d = mem_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // A reload takes priority over the pop increment.
    if (load_addr) begin
      addr_d = start_addr;
    end else if (pop_s) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d = addr_q;
    end

    // New error beats a same-cycle clear.
    if (accept_s && !enc_legal_s) begin
      err_illegal_d = 1'b1;
    end else if (err_clr) begin
      err_illegal_d = 1'b0;
    end else begin
      err_illegal_d = err_illegal_q;
    end

    if (accept_s && enc_itype_s && (in_imm[25:16] != 10'd0)) begin
      err_range_d = 1'b1;
    end else if (err_clr) begin
      err_range_d = 1'b0;
    end else begin
      err_range_d = err_range_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      addr_q        <= '0;
      err_illegal_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      addr_q        <= addr_d;
      err_illegal_q <= err_illegal_d;
      err_range_q   <= err_range_d;
    end
  end

  // Head word, forced to zero while the FIFO is empty.
  always_comb begin
    if (empty_s) begin
      out_instr = 32'h0000_0000;
    end else begin
      out_instr = mem_q[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign out_addr    = addr_q;
  assign err_illegal = err_illegal_q;
  assign err_range   = err_range_q;

`ifdef ENC_STATS_EN
  logic [15:0] count_q, count_d;

  // Saturating count of completed pops.
  always_comb begin
    if (pop_s && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Pop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule
